packet_fifo_buffer: RTL and testbench

//  Parametrised circular byte/word buffer between the protocol engine and the bus-side interface.

---
 rtl/packet_fifo_buffer.sv | 138 +++++++++++++
 tb/tb_packet_fifo_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_fifo_buffer.sv
// rtl/packet_fifo_buffer.sv - circular buffer with commit/rewind packet retry
module packet_fifo_buffer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 64,
    parameter int AF_THRESH   = 56,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       commit,
    input  logic                       rewind,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_W   = CW'(DEPTH);
    localparam logic [CW-1:0] AF_W      = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam bit            AUTO      = (AUTO_COMMIT != 0);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] cptr;
    logic [CW-1:0] held;

    logic [AW-1:0] rptr_n;
    logic [AW-1:0] cptr_n;
    logic [CW-1:0] occ_n;
    logic [CW-1:0] held_n;

    logic          do_rewind;
    logic          do_commit;
    logic          push;
    logic          pop;
    logic [CW-1:0] push_cnt;
    logic [CW-1:0] pop_cnt;
    logic [AW-1:0] push_ptr;
    logic [AW-1:0] pop_ptr;

    // Status decodes come only from registered counters, never from inputs.
    assign empty       = (occupancy == '0);
    assign full        = (held == DEPTH_W);
    assign almost_full = (held >= AF_W);

    assign do_rewind = rewind && !AUTO;
    assign do_commit = commit && !AUTO;

    // Space is bounded by held, not occupancy: popped-but-uncommitted words still own their slots.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty && !do_rewind;

    assign push_cnt = push ? CNT_ONE : '0;
    assign pop_cnt  = pop  ? CNT_ONE : '0;
    assign push_ptr = push ? PTR_ONE : '0;
    assign pop_ptr  = pop  ? PTR_ONE : '0;

    always_comb begin
        rptr_n = rptr;
        cptr_n = cptr;
        occ_n  = occupancy;
        held_n = held;
        if (do_rewind) begin
            rptr_n = cptr;
            occ_n  = held + push_cnt;
            held_n = held + push_cnt;
        end else begin
            rptr_n = rptr + pop_ptr;
            occ_n  = occupancy + push_cnt - pop_cnt;
            if (AUTO || do_commit) begin
                cptr_n = rptr_n;
                held_n = occ_n;
            end else begin
                held_n = held + push_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cptr      <= '0;
            occupancy <= '0;
            held      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            cptr      <= '0;
            occupancy <= '0;
            held      <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr + push_ptr;
            rptr      <= rptr_n;
            cptr      <= cptr_n;
            occupancy <= occ_n;
            held      <= held_n;
            rd_valid  <= pop;
            if (pop) begin
                rd_data <= mem[rptr];
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty && !do_rewind) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_fifo_buffer.sv
// tb/tb_packet_fifo_buffer.sv - self-checking bench for packet_fifo_buffer
module tb_packet_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst, clear, wr_en, rd_en, commit, rewind;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, almost_full, overflow, underflow;
    logic [6:0] occupancy;

    logic       b_rst, b_clear, b_wr_en, b_rd_en, b_commit, b_rewind;
    logic [7:0] b_wr_data;
    logic [7:0] b_rd_data;
    logic       b_rd_valid, b_empty, b_full, b_almost_full, b_overflow, b_underflow;
    logic [2:0] b_occupancy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_fifo_buffer #(.WIDTH(8), .DEPTH(64), .AF_THRESH(56), .AUTO_COMMIT(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .commit(commit),
        .rewind(rewind), .occupancy(occupancy), .empty(empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    packet_fifo_buffer #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AUTO_COMMIT(1)) dut_auto (
        .clk(clk), .rst(b_rst), .clear(b_clear), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .commit(b_commit),
        .rewind(b_rewind), .occupancy(b_occupancy), .empty(b_empty), .full(b_full),
        .almost_full(b_almost_full), .overflow(b_overflow), .underflow(b_underflow)
    );

    // Reference model: held words kept in a queue from the checkpoint onward;
    // m_rd counts how many of them have been popped since the checkpoint.
    logic [7:0] mq[$];
    int         m_rd;
    logic [7:0] m_rd_data;
    bit         m_rv, m_ov, m_uf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit w, input logic [7:0] d,
                              input bit re, input bit cm, input bit rw);
        int  occ;
        bit  was_full;
        if (r || c) begin
            mq.delete();
            m_rd = 0;
            m_rv = 0;
            m_ov = 0;
            m_uf = 0;
            if (r) m_rd_data = 8'h00;
            return;
        end
        occ      = mq.size() - m_rd;
        was_full = (mq.size() == 64);
        m_rv     = 0;
        if (rw) begin
            m_rd = 0;
        end else if (re) begin
            if (occ > 0) begin
                m_rd_data = mq[m_rd];
                m_rd++;
                m_rv = 1;
            end else begin
                m_uf = 1;
            end
        end
        if (w) begin
            if (was_full) m_ov = 1;
            else mq.push_back(d);
        end
        if (cm && !rw) begin
            repeat (m_rd) void'(mq.pop_front());
            m_rd = 0;
        end
    endtask

    task automatic check_model();
        int occ;
        occ = mq.size() - m_rd;
        check("occupancy", int'(occupancy), occ);
        check("empty", int'(empty), int'(occ == 0));
        check("full", int'(full), int'(mq.size() == 64));
        check("almost_full", int'(almost_full), int'(mq.size() >= 56));
        check("rd_valid", int'(rd_valid), int'(m_rv));
        check("rd_data", int'(rd_data), int'(m_rd_data));
        check("overflow", int'(overflow), int'(m_ov));
        check("underflow", int'(underflow), int'(m_uf));
    endtask

    task automatic cycle(input bit r, input bit c, input bit w, input logic [7:0] d,
                         input bit re, input bit cm, input bit rw);
        @(negedge clk);
        rst = r; clear = c; wr_en = w; wr_data = d; rd_en = re; commit = cm; rewind = rw;
        @(posedge clk);
        model_step(r, c, w, d, re, cm, rw);
        #1;
        check_model();
    endtask

    task automatic bcycle(input bit r, input bit w, input logic [7:0] d,
                          input bit re, input bit cm, input bit rw);
        @(negedge clk);
        b_rst = r; b_clear = 1'b0; b_wr_en = w; b_wr_data = d; b_rd_en = re;
        b_commit = cm; b_rewind = rw;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         clr, wr, rd, cm, rw;
        logic [7:0] d;
        int         occ;
        bit         rv;
        logic [7:0] rdata;
        bit         uf;
    } vec_t;

    vec_t vt[12];

    initial begin
        rst = 1; clear = 0; wr_en = 0; wr_data = 0; rd_en = 0; commit = 0; rewind = 0;
        b_rst = 1; b_clear = 0; b_wr_en = 0; b_wr_data = 0; b_rd_en = 0; b_commit = 0; b_rewind = 0;
        m_rd_data = 8'h00;

        vt[0]  = '{0,1,0,0,0, 8'hA5, 1, 0, 8'h00, 0};
        vt[1]  = '{0,1,0,0,0, 8'h3C, 2, 0, 8'h00, 0};
        vt[2]  = '{0,0,1,0,0, 8'h00, 1, 1, 8'hA5, 0};
        vt[3]  = '{0,1,1,0,0, 8'h77, 1, 1, 8'h3C, 0};
        vt[4]  = '{0,0,0,0,1, 8'h00, 3, 0, 8'h3C, 0};
        vt[5]  = '{0,0,1,0,0, 8'h00, 2, 1, 8'hA5, 0};
        vt[6]  = '{0,0,1,1,0, 8'h00, 1, 1, 8'h3C, 0};
        vt[7]  = '{0,0,0,0,1, 8'h00, 1, 0, 8'h3C, 0};
        vt[8]  = '{0,0,1,0,0, 8'h00, 0, 1, 8'h77, 0};
        vt[9]  = '{0,0,1,0,0, 8'h00, 0, 0, 8'h77, 1};
        vt[10] = '{0,0,1,0,1, 8'h00, 1, 0, 8'h77, 1};
        vt[11] = '{1,0,0,0,0, 8'h00, 0, 0, 8'h77, 0};

        // reset state
        cycle(1, 0, 0, 8'h00, 0, 0, 0);
        check("reset_occ", int'(occupancy), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);

        for (int i = 0; i < 12; i++) begin
            cycle(0, vt[i].clr, vt[i].wr, vt[i].d, vt[i].rd, vt[i].cm, vt[i].rw);
            check($sformatf("vec%0d_occ", i), int'(occupancy), vt[i].occ);
            check($sformatf("vec%0d_rv", i), int'(rd_valid), int'(vt[i].rv));
            check($sformatf("vec%0d_rdata", i), int'(rd_data), int'(vt[i].rdata));
            check($sformatf("vec%0d_uf", i), int'(underflow), int'(vt[i].uf));
        end

        // fill to full, watching almost_full edge at the 56th push
        cycle(1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 1, 8'(i), 0, 0, 0);
            check($sformatf("fill%0d_af", i), int'(almost_full), int'(i + 1 >= 56));
        end
        check("fill_full", int'(full), 1);
        check("fill_occ", int'(occupancy), 64);
        cycle(0, 0, 1, 8'hEE, 0, 0, 0);
        check("push65_overflow", int'(overflow), 1);
        check("push65_occ", int'(occupancy), 64);

        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 8'h00, 1, 0, 0);
            check($sformatf("pop%0d_data", i), int'(rd_data), i);
            check($sformatf("pop%0d_valid", i), int'(rd_valid), 1);
        end
        check("pop4_occ", int'(occupancy), 60);
        check("pop4_full_held", int'(full), 1);
        cycle(0, 0, 0, 8'h00, 0, 1, 0);
        check("commit_full", int'(full), 0);

        // rewind replay
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 8'h00, 1, 0, 0);
            check($sformatf("rpop%0d_data", i), int'(rd_data), 4 + i);
        end
        cycle(0, 0, 0, 8'h00, 0, 0, 1);
        check("rewind_occ", int'(occupancy), 60);
        cycle(0, 0, 0, 8'h00, 1, 0, 0);
        check("replay_data", int'(rd_data), 4);
        cycle(0, 0, 0, 8'h00, 0, 1, 1);
        check("commit_rewind_occ", int'(occupancy), 60);

        // steady push+pop+commit across the pointer wrap
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 8'(8'h80 + i), 1, 1, 0);
            check($sformatf("steady%0d_occ", i), int'(occupancy), 60);
        end

        // underflow then clear keeps rd_data
        cycle(0, 1, 0, 8'h00, 0, 0, 0);
        cycle(0, 0, 1, 8'h5A, 0, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0, 0);
        cycle(0, 0, 0, 8'h00, 1, 0, 0);
        check("empty_rd_valid", int'(rd_valid), 0);
        check("empty_underflow", int'(underflow), 1);
        cycle(0, 1, 1, 8'h11, 1, 0, 0);
        check("clear_uf", int'(underflow), 0);
        check("clear_ov", int'(overflow), 0);
        check("clear_occ", int'(occupancy), 0);
        check("clear_rd_data", int'(rd_data), 8'h5A);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int  bias;
            bias = (i / 400) % 2 == 0 ? 70 : 30;
            cycle(0, $urandom_range(0, 499) == 0, $urandom_range(0, 99) < bias, 8'($urandom),
                  $urandom_range(0, 99) < (100 - bias), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0);
        end

        // reset mid-burst
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(i), 1, 0, 0);
        cycle(1, 0, 1, 8'hFF, 1, 1, 0);
        check("midrst_occ", int'(occupancy), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        check("midrst_rd_valid", int'(rd_valid), 0);
        check("midrst_empty", int'(empty), 1);

        // AUTO_COMMIT build, DEPTH=4
        bcycle(1, 0, 8'h00, 0, 0, 0);
        check("auto_reset_empty", int'(b_empty), 1);
        for (int i = 1; i <= 4; i++) bcycle(0, 1, 8'(i), 0, 0, 0);
        check("auto_full", int'(b_full), 1);
        check("auto_af", int'(b_almost_full), 1);
        bcycle(0, 1, 8'h05, 0, 0, 0);
        check("auto_overflow", int'(b_overflow), 1);
        check("auto_occ4", int'(b_occupancy), 4);
        bcycle(0, 0, 8'h00, 1, 0, 0);
        check("auto_pop1", int'(b_rd_data), 1);
        check("auto_freed", int'(b_full), 0);
        bcycle(0, 1, 8'h06, 0, 0, 0);
        check("auto_refill_occ", int'(b_occupancy), 4);
        bcycle(0, 0, 8'h00, 1, 0, 1);
        check("auto_rewind_ignored_data", int'(b_rd_data), 2);
        check("auto_rewind_ignored_occ", int'(b_occupancy), 3);
        bcycle(0, 0, 8'h00, 1, 0, 0);
        check("auto_pop3", int'(b_rd_data), 3);
        bcycle(0, 0, 8'h00, 1, 0, 0);
        check("auto_pop4", int'(b_rd_data), 4);
        bcycle(0, 0, 8'h00, 1, 0, 0);
        check("auto_pop6", int'(b_rd_data), 6);
        check("auto_empty", int'(b_empty), 1);
        check("auto_no_underflow", int'(b_underflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
